// File: rtl/w5300_bus_arbiter.sv
// ---------------------------------------------------------------------------
// w5300_bus_arbiter
//
// Round-robin arbiter sharing the single W5300 register-bus access engine
// among NC socket clients. One client is granted at a time; its operations
// are forwarded to the bus driver one by one, and the completion pulse and
// read data are returned to it. A per-grant operation budget (MAX_OPS)
// forces rotation when other clients are waiting (0 = unlimited).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cli_req[NC]             client i requests the bus for a sequence of ops
//   cli_addr[NC*10]         client i {RD/WR flag, 9-bit register}
//   cli_wr_data[NC*16]      client i write data
//   cli_grant[NC]           one-hot (or zero) current owner
//   cli_op_state[NC]        one-cycle completion pulse to the owner
//   cli_rd_data[16]         read data broadcast (bus_rd_data passthrough)
//   bus_start               one-cycle operation start to the bus driver
//   bus_addr[10]            operation address, held until bus_done
//   bus_wr_data[16]         operation write data, held until bus_done
//   bus_rd_data[16]         driver read data, valid with bus_done
//   bus_done                one-cycle operation completion from the driver
// ---------------------------------------------------------------------------
module w5300_bus_arbiter #(
    parameter int NC      = 4,
    parameter int MAX_OPS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NC-1:0]      cli_req,
    input  logic [NC*10-1:0]   cli_addr,
    input  logic [NC*16-1:0]   cli_wr_data,
    output logic [NC-1:0]      cli_grant,
    output logic [NC-1:0]      cli_op_state,
    output logic [15:0]        cli_rd_data,
    output logic               bus_start,
    output logic [9:0]         bus_addr,
    output logic [15:0]        bus_wr_data,
    input  logic [15:0]        bus_rd_data,
    input  logic               bus_done
);

    localparam int PTR_W = (NC > 1) ? $clog2(NC) : 1;
    localparam int CNT_W = (MAX_OPS > 0) ? $clog2(MAX_OPS + 1) : 1;
    localparam logic [CNT_W:0] BUDGET = (CNT_W + 1)'(MAX_OPS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [PTR_W-1:0] ptr_q,     ptr_d;
    logic [PTR_W-1:0] gidx_q,    gidx_d;
    logic [NC-1:0]    grant_q,   grant_d;
    logic [CNT_W-1:0] op_cnt_q,  op_cnt_d;
    logic             start_q,   start_d;
    logic [9:0]       addr_q,    addr_d;
    logic [15:0]      wdata_q,   wdata_d;

    // Round-robin search: first requester at or above ptr, wrapping modulo NC.
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;
    logic [PTR_W:0]   cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NC; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NC)) begin
                cand = cand - (PTR_W + 1)'(NC);
            end
            if (!pick_vld && cli_req[cand[PTR_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Operation fields of the granted client.
    logic [9:0]  sel_addr;
    logic [15:0] sel_wdata;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NC; i++) begin
            if (gidx_q == PTR_W'(i)) begin
                sel_addr  = cli_addr[i*10 +: 10];
                sel_wdata = cli_wr_data[i*16 +: 16];
            end
        end
    end

    logic             sel_req;
    logic             others_req;
    logic             budget_hit;
    logic [PTR_W-1:0] ptr_next;

    assign sel_req    = cli_req[gidx_q];
    assign others_req = |(cli_req & ~grant_q);
    // True on the operation that uses up the grant's budget.
    assign budget_hit = (MAX_OPS != 0) &&
                        (({1'b0, op_cnt_q} + (CNT_W + 1)'(1)) == BUDGET);
    // After a release the search resumes just past the previous owner.
    assign ptr_next   = (gidx_q == PTR_W'(NC - 1)) ? '0 : gidx_q + PTR_W'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        op_cnt_d = op_cnt_q;
        start_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gidx_d   = pick_idx;
                    grant_d  = NC'(1) << pick_idx;
                    op_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!sel_req) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The operation always runs to completion; a dropped request
                // only takes effect once bus_done arrives.
                if (bus_done) begin
                    op_cnt_d = op_cnt_q + CNT_W'(1);
                    if (!sel_req || (budget_hit && others_req)) begin
                        grant_d = '0;
                        ptr_d   = ptr_next;
                        state_d = ST_IDLE;
                    end else begin
                        if (budget_hit) begin
                            op_cnt_d = '0;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            op_cnt_q <= '0;
            start_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            op_cnt_q <= op_cnt_d;
            start_q  <= start_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign cli_grant    = grant_q;
    // bus_done outside WAIT is ignored.
    assign cli_op_state = (bus_done && (state_q == ST_WAIT)) ? grant_q : '0;
    assign cli_rd_data  = bus_rd_data;
    assign bus_start    = start_q;
    assign bus_addr     = addr_q;
    assign bus_wr_data  = wdata_q;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
module tb_w5300_bus_arbiter;

    localparam int NC = 4;
    localparam int MO = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     cli_req;
    logic [NC*10-1:0]  cli_addr;
    logic [NC*16-1:0]  cli_wr_data;
    logic [NC-1:0]     cli_grant;
    logic [NC-1:0]     cli_op_state;
    logic [15:0]       cli_rd_data;
    logic              bus_start;
    logic [9:0]        bus_addr;
    logic [15:0]       bus_wr_data;
    logic [15:0]       bus_rd_data;
    logic              bus_done;

    // Second instance: two clients, unlimited budget.
    logic [1:0]        u_req;
    logic [19:0]       u_addr;
    logic [31:0]       u_wdata;
    logic [1:0]        u_grant;
    logic [1:0]        u_os;
    logic [15:0]       u_rd;
    logic              u_start;
    logic [9:0]        u_baddr;
    logic [15:0]       u_bwd;
    logic [15:0]       u_brd;
    logic              u_done;

    always #5 clk = ~clk;

    w5300_bus_arbiter #(.NC(NC), .MAX_OPS(MO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cli_req(cli_req), .cli_addr(cli_addr), .cli_wr_data(cli_wr_data),
        .cli_grant(cli_grant), .cli_op_state(cli_op_state), .cli_rd_data(cli_rd_data),
        .bus_start(bus_start), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_done(bus_done)
    );

    w5300_bus_arbiter #(.NC(2), .MAX_OPS(0)) u_unl (
        .clk(clk), .rst_n(rst_n),
        .cli_req(u_req), .cli_addr(u_addr), .cli_wr_data(u_wdata),
        .cli_grant(u_grant), .cli_op_state(u_os), .cli_rd_data(u_rd),
        .bus_start(u_start), .bus_addr(u_baddr), .bus_wr_data(u_bwd),
        .bus_rd_data(u_brd), .bus_done(u_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int            cyc;
    int            owner;        // current grantee, -1 when none
    int            cnt;          // ops completed in this grant
    int            ptr;          // round-robin search start
    bit            eval_due;     // arbitration decision happens this cycle
    bit            issue_due;    // owner's next op is picked up this cycle
    bit            outstanding;  // op in flight on the bus
    bit            start_due;    // bus_start expected at next sample
    logic [NC-1:0] exp_grant;
    int            op_cli;
    int            done_at;
    logic [9:0]    op_addr;
    logic [15:0]   op_data;
    bit            arrivals_en;

    // client-side state
    int            ops_left [NC];
    logic [9:0]    caddr    [NC];
    logic [15:0]   cdata    [NC];

    function automatic logic [NC-1:0] onehot(input int i);
        logic [NC-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic int first_from(input logic [NC-1:0] r, input int p);
        for (int k = 0; k < NC; k++) begin
            if (r[(p + k) % NC]) return (p + k) % NC;
        end
        return -1;
    endfunction

    task automatic new_op(input int c);
        caddr[c] = 10'($urandom_range(0, 1023));
        cdata[c] = 16'($urandom_range(0, 65535));
    endtask

    task automatic drive_clients();
        for (int c = 0; c < NC; c++) begin
            cli_req[c]             = (ops_left[c] > 0);
            cli_addr[c*10 +: 10]   = caddr[c];
            cli_wr_data[c*16 +: 16] = cdata[c];
        end
    endtask

    task automatic model_reset();
        owner       = -1;
        cnt         = 0;
        ptr         = 0;
        eval_due    = 1'b1;
        issue_due   = 1'b0;
        outstanding = 1'b0;
        start_due   = 1'b0;
        exp_grant   = '0;
    endtask

    task automatic release_bus(output logic [NC-1:0] g);
        ptr      = (owner + 1) % NC;
        owner    = -1;
        g        = '0;
        eval_due = 1'b1;
    endtask

    // Decide what the arbiter must do next from this cycle's requests.
    task automatic model_advance(input logic [NC-1:0] r, input bit done);
        logic [NC-1:0] nxt_grant;
        bit            nxt_start;
        bit            others;
        nxt_grant = exp_grant;
        nxt_start = 1'b0;
        if (eval_due) begin
            if (r != 0) begin
                owner     = first_from(r, ptr);
                cnt       = 0;
                nxt_grant = onehot(owner);
                eval_due  = 1'b0;
                issue_due = 1'b1;
            end
        end else if (issue_due) begin
            issue_due = 1'b0;
            if (!r[owner]) release_bus(nxt_grant);
            else nxt_start = 1'b1;
        end else if (done) begin
            outstanding = 1'b0;
            cnt++;
            others = (r & ~onehot(owner)) != 0;
            if (ops_left[op_cli] > 0) begin
                ops_left[op_cli]--;
                new_op(op_cli);
            end
            if (!r[owner] || (MO != 0 && cnt == MO && others)) begin
                release_bus(nxt_grant);
            end else begin
                if (MO != 0 && cnt == MO) cnt = 0;
                issue_due = 1'b1;
            end
        end
        start_due = nxt_start;
        exp_grant = nxt_grant;
    endtask

    task automatic step();
        logic [NC-1:0] exp_os;
        @(negedge clk);
        cyc++;
        chk("grant", 32'(cli_grant), 32'(exp_grant));
        chk("bus_start", 32'(bus_start), 32'(start_due));
        if (start_due) begin
            outstanding = 1'b1;
            op_cli      = owner;
            op_addr     = caddr[owner];
            op_data     = cdata[owner];
            done_at     = cyc + $urandom_range(0, 4);
        end
        if (outstanding) begin
            chk("bus_addr", 32'(bus_addr), 32'(op_addr));
            chk("bus_wr_data", 32'(bus_wr_data), 32'(op_data));
        end
        // occasionally the owner gives up while its op is on the bus
        if (outstanding && $urandom_range(0, 15) == 0) ops_left[op_cli] = 0;
        if (arrivals_en) begin
            for (int c = 0; c < NC; c++) begin
                if (c != owner && ops_left[c] == 0 && $urandom_range(0, 19) == 0) begin
                    ops_left[c] = $urandom_range(1, 6);
                    new_op(c);
                end
            end
        end
        drive_clients();
        bus_done    = outstanding ? (cyc == done_at) : ($urandom_range(0, 3) == 0);
        bus_rd_data = 16'($urandom_range(0, 65535));
        #1;
        exp_os = (outstanding && bus_done) ? onehot(op_cli) : '0;
        chk("op_state", 32'(cli_op_state), 32'(exp_os));
        chk("rd_data", 32'(cli_rd_data), 32'(bus_rd_data));
        model_advance(cli_req, outstanding && bus_done);
    endtask

    function automatic bit all_quiet();
        for (int c = 0; c < NC; c++) if (ops_left[c] != 0) return 1'b0;
        return (owner == -1) && !outstanding && eval_due;
    endfunction

    initial begin
        bit found;
        int p0;
        int ops0;
        bit got1;
        logic [9:0] a0;

        rst_n       = 1'b0;
        cli_req     = '0;
        cli_addr    = '0;
        cli_wr_data = '0;
        bus_rd_data = '0;
        bus_done    = 1'b0;
        u_req       = '0;
        u_addr      = '0;
        u_wdata     = 32'hA5A5_5A5A;
        u_brd       = '0;
        u_done      = 1'b0;
        cyc         = 0;
        arrivals_en = 1'b0;
        for (int c = 0; c < NC; c++) begin
            ops_left[c] = 0;
            caddr[c]    = '0;
            cdata[c]    = '0;
        end
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(cli_grant), 0);
        chk("rst_start", 32'(bus_start), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        chk("rst_wdata", 32'(bus_wr_data), 0);
        chk("rst_op_state", 32'(cli_op_state), 0);
        chk("rst_u_grant", 32'(u_grant), 0);
        rst_n = 1'b1;

        // randomized traffic, all clients busy at the start
        for (int c = 0; c < NC; c++) begin
            ops_left[c] = $urandom_range(2, 6);
            new_op(c);
        end
        arrivals_en = 1'b1;
        repeat (1500) step();

        // reset while client 2 has an op in flight
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            step();
            if (outstanding && owner == 2 && cyc != done_at) found = 1'b1;
        end
        chk("find_owner2_wait", 32'(found), 1);
        rst_n    = 1'b0;
        bus_done = 1'b0;
        #1;
        chk("midrst_grant", 32'(cli_grant), 0);
        chk("midrst_start", 32'(bus_start), 0);
        chk("midrst_addr", 32'(bus_addr), 0);
        chk("midrst_wdata", 32'(bus_wr_data), 0);
        @(negedge clk);
        bus_done = 1'b1;
        #1;
        chk("midrst_op_state", 32'(cli_op_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NC; c++) ops_left[c] = 0;
        drive_clients();
        bus_done = 1'b1;  // late completion from before the reset
        #1;
        chk("late_done_op_state", 32'(cli_op_state), 0);
        chk("late_done_grant", 32'(cli_grant), 0);
        model_reset();
        arrivals_en = 1'b0;
        for (int c = 0; c < NC; c++) begin
            ops_left[c] = 3;
            new_op(c);
        end
        step();
        step();
        chk("post_rst_grant0", 32'(cli_grant), 32'(4'b0001));
        arrivals_en = 1'b1;
        repeat (400) step();

        // drain
        arrivals_en = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 1000 && !found; t++) begin
            step();
            if (all_quiet()) found = 1'b1;
        end
        chk("drain", 32'(found), 1);
        bus_done = 1'b0;

        // unlimited budget: client 0 keeps the bus for all 20 ops
        ops0 = 20;
        p0   = 0;
        got1 = 1'b0;
        a0   = 10'h011;
        u_addr = {10'h155, a0};
        u_req  = 2'b11;
        for (int t = 0; t < 600 && !got1; t++) begin
            @(negedge clk);
            if (u_grant == 2'b10) got1 = 1'b1;
            if (ops0 > 0) begin
                chk("u_hold", 32'(u_grant[1]), 0);
                if (u_start) chk("u_addr", 32'(u_baddr), 32'(a0));
            end
            u_done = u_start;  // completion coincident with start
            u_brd  = 16'($urandom_range(0, 65535));
            #1;
            if (ops0 > 0) chk("u_op_state", 32'(u_os), u_done ? 32'd1 : 32'd0);
            if (u_os[0]) begin
                p0++;
                ops0--;
                a0 = 10'($urandom_range(0, 1023));
                u_addr[9:0] = a0;
                if (ops0 == 0) u_req[0] = 1'b0;
            end
        end
        chk("u_ops0", 32'(p0), 20);
        chk("u_grant1", 32'(got1), 1);
        u_req  = '0;
        u_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/w5300_bus_arbiter.md
# w5300_bus_arbiter

Round-robin arbiter that shares the single W5300 register-bus access engine among `NC` socket clients (per-socket transmitters, receivers, configuration sequencer). Each client keeps its existing `addr`/`wr_data`/`rd_data`/`op_state` handshake: it presents one operation and advances only when `op_state` pulses. The arbiter grants one client, forwards its operations to the bus driver one at a time, and returns completion and read data. A per-grant operation budget bounds how long one client can hold the bus.

## Interface
- `NC`, 4: number of clients, 2..8.
- `MAX_OPS`, 16: operations per grant before forced rotation when others wait; 0 = unlimited.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cli_req`  in  NC  client i requests the bus; held high for the whole operation sequence.
- `cli_addr`  in  NC*10  client i `{RD/WR flag, 9-bit register}` at bits [10i+9:10i].
- `cli_wr_data`  in  NC*16  client i write data at bits [16i+15:16i].
- `cli_grant`  out  NC  one-hot (or zero) current owner.
- `cli_op_state`  out  NC  one-cycle completion pulse to the owner only.
- `cli_rd_data`  out  16  read data, broadcast (`bus_rd_data` passthrough).
- `bus_start`  out  1  one-cycle operation start to the bus driver.
- `bus_addr`  out  10  operation address, held from `bus_start` until `bus_done`.
- `bus_wr_data`  out  16  operation write data, held likewise.
- `bus_rd_data`  in  16  driver read data, valid with `bus_done`.
- `bus_done`  in  1  one-cycle operation completion from the driver.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any `cli_req`, grant the first requester searching from `ptr` upward, modulo NC; `cli_grant` registered; `op_cnt`<=0; go to ISSUE. `ptr` resets to 0.
- ISSUE (one cycle): if `cli_req[g]`=0, clear grant, set `ptr`=g+1 mod NC, go to IDLE with no bus op. Otherwise capture `cli_addr[g]` and `cli_wr_data[g]` into `bus_addr` and `bus_wr_data`, set `bus_start`=1 for the next cycle, and go to WAIT.
- WAIT: when `bus_done` is high, `cli_op_state[g]` = 1 in the same cycle (combinational: `bus_done` & WAIT & `cli_grant[g]`), and `op_cnt`++. The next state is decided from values in the `bus_done` cycle:
  - Release when `cli_req[g]`=0, or when `MAX_OPS`!=0, `op_cnt`+1=`MAX_OPS`, and another `cli_req` bit is high. Release means: clear grant, set `ptr`=g+1 mod NC, go to IDLE.
  - If the budget is reached with no other requester: set `op_cnt`<=0 and go to ISSUE.
  - Otherwise go to ISSUE.
- A client dropping `cli_req` during WAIT does not abort the operation. It completes, `op_state` is still pulsed, then the grant is released.
- `bus_done` outside WAIT is ignored and produces no `cli_op_state`.
- `op_cnt` width is clog2(`MAX_OPS`+1), minimum 1. It is unused when `MAX_OPS`=0.

## Timing
- Reset values: `cli_grant`=0, `cli_op_state`=0, `bus_start`=0, `bus_addr`=0, `bus_wr_data`=0, state IDLE, `ptr`=0. `cli_rd_data` follows `bus_rd_data`.
- Reset asserted mid-operation: all outputs return to reset values immediately. An in-flight `bus_done` is dropped, and the driver is reset by the same `rst_n`.
- First operation: `cli_req` high in IDLE at cycle 0 → `cli_grant` at cycle 1 (ISSUE) → `bus_start` at cycle 2.
- Back-to-back: `bus_done` at cycle k → ISSUE at k+1 (client address already advanced) → `bus_start` at k+2. Per-operation overhead is 2 cycles plus driver latency.
- Handover: `bus_done` at k with release → IDLE at k+1 → new grant at k+2 → `bus_start` at k+3.
- `bus_done` coincident with `bus_start` is accepted.
- `bus_start` is high for exactly one cycle per operation. At most one operation is outstanding.
- `cli_grant` never changes while in WAIT.

## Test plan
- Single client 0, 3 ops, driver latency 4: grant at cycle 1, `bus_start` at cycles 2, 8, 14; 3 `op_state` pulses; `bus_addr` matches each presented address; release after `req` drops.
- Clients 0, 1, 2 requesting continuously, `MAX_OPS`=2: grant order 0,0,1,1,2,2,0…; each handover gap is 3 cycles from `bus_done` to `bus_start`.
- `MAX_OPS`=2, only client 3 requesting 5 ops: no release; `op_cnt` wraps; 5 pulses, all to client 3.
- Client 1 drops `req` mid-WAIT: read of `0x1234` still completes, `cli_op_state[1]` pulses with `cli_rd_data`=`0x1234`, then client 2 (pending) is granted next.
- `rst_n` low during WAIT, then high: all outputs 0; late `bus_done` produces no `op_state`; the next grant starts from client 0.
- `MAX_OPS`=0, clients 0 and 1 requesting: client 0 keeps the bus for all 20 ops until `req` drops, then client 1 is granted.
